// File: rtl/mul8_dot_acc.sv
// Streaming dot-product accumulator for 16-bit unsigned products with valid/ready result handoff.
// Optional macro MUL8_DOT_ACC_SAT_EN: saturate the accumulator on overflow instead of wrapping.
module mul8_dot_acc #(
    parameter int ACC_W   = 20,
    parameter int MAX_LEN = 16,
    parameter int CNT_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_prod,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

    state_t             state_reg, state_next;
    logic [ACC_W-1:0]   acc_reg, acc_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               ovf_reg, ovf_next;
    logic               valid_reg, valid_next;
    logic [ACC_W-1:0]   sum_reg, sum_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic               oovf_reg, oovf_next;

    logic               accept;
    logic               close;
    logic [ACC_W:0]     sum_ext;
    logic [CNT_W-1:0]   cnt_inc;
    logic               ovf_acc;
    logic [ACC_W-1:0]   acc_sum;

    // acc/cnt/ovf are zero whenever no vector is open, so IDLE and ACC share one datapath.
    always_comb begin
        accept  = in_valid & ~valid_reg;
        sum_ext = {1'b0, acc_reg} + (ACC_W+1)'(in_prod);
        cnt_inc = cnt_reg + CNT_W'(1);
        ovf_acc = ovf_reg | sum_ext[ACC_W];
`ifdef MUL8_DOT_ACC_SAT_EN
        acc_sum = ovf_acc ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
        acc_sum = sum_ext[ACC_W-1:0];
`endif
        close   = accept & (in_last | (cnt_inc == CNT_W'(MAX_LEN)));
    end

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        cnt_next   = cnt_reg;
        ovf_next   = ovf_reg;
        valid_next = valid_reg;
        sum_next   = sum_reg;
        count_next = count_reg;
        oovf_next  = oovf_reg;
        case (state_reg)
            IDLE, ACC: begin
                if (close) begin
                    state_next = HOLD;
                    sum_next   = acc_sum;
                    count_next = cnt_inc;
                    oovf_next  = ovf_acc;
                    valid_next = 1'b1;
                    acc_next   = '0;
                    cnt_next   = '0;
                    ovf_next   = 1'b0;
                end else if (accept) begin
                    state_next = ACC;
                    acc_next   = acc_sum;
                    cnt_next   = cnt_inc;
                    ovf_next   = ovf_acc;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_next = IDLE;
                    valid_next = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            ovf_reg   <= 1'b0;
            valid_reg <= 1'b0;
            sum_reg   <= '0;
            count_reg <= '0;
            oovf_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            cnt_reg   <= cnt_next;
            ovf_reg   <= ovf_next;
            valid_reg <= valid_next;
            sum_reg   <= sum_next;
            count_reg <= count_next;
            oovf_reg  <= oovf_next;
        end
    end

    assign in_ready  = ~valid_reg;
    assign out_valid = valid_reg;
    assign out_sum   = sum_reg;
    assign out_count = count_reg;
    assign out_ovf   = oovf_reg;

endmodule

// File: tb/tb_mul8_dot_acc.sv
// Scoreboard bench: directed vectors push expected results; monitors pop on each output handshake.
module tb_mul8_dot_acc;

    typedef struct {
        longint sum;
        int     count;
        bit     ovf;
    } exp_t;

    logic        clk = 0;
    logic        rst;

    logic        a_in_valid, a_in_ready, a_in_last, a_out_valid, a_out_ready, a_out_ovf;
    logic [15:0] a_in_prod;
    logic [19:0] a_out_sum;
    logic [4:0]  a_out_count;

    logic        b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready, b_out_ovf;
    logic [15:0] b_in_prod;
    logic [15:0] b_out_sum;
    logic [4:0]  b_out_count;

    exp_t qa[$];
    exp_t qb[$];
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    mul8_dot_acc #(.ACC_W(20), .MAX_LEN(16), .CNT_W(5)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_prod(a_in_prod), .in_last(a_in_last),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_sum(a_out_sum), .out_count(a_out_count), .out_ovf(a_out_ovf)
    );

    mul8_dot_acc #(.ACC_W(16), .MAX_LEN(16), .CNT_W(5)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_prod(b_in_prod), .in_last(b_in_last),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_sum(b_out_sum), .out_count(b_out_count), .out_ovf(b_out_ovf)
    );

    task automatic compare(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end else begin
            $display("PASS %s value=%0d", name, act);
        end
    endtask

    task automatic push(input bit sel, input longint sum, input int count, input bit ovf);
        exp_t e;
        e.sum = sum; e.count = count; e.ovf = ovf;
        if (sel) qb.push_back(e); else qa.push_back(e);
    endtask

    task automatic send(input bit sel, input int prod, input bit last);
        int n;
        n = 0;
        if (!sel) begin
            a_in_valid = 1; a_in_prod = prod[15:0]; a_in_last = last;
            while (!a_in_ready && n < 50) begin @(posedge clk); #1; n++; end
        end else begin
            b_in_valid = 1; b_in_prod = prod[15:0]; b_in_last = last;
            while (!b_in_ready && n < 50) begin @(posedge clk); #1; n++; end
        end
        if (n >= 50) begin
            tests++; fails++;
            $display("FAIL send_timeout dut=%0d actual=stalled required=accept", sel);
        end
        @(posedge clk); #1;
        a_in_valid = 0; a_in_last = 0;
        b_in_valid = 0; b_in_last = 0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && a_out_valid && a_out_ready) begin
            tests++;
            if (qa.size() == 0) begin
                fails++;
                $display("FAIL a_unexpected sum=%0d count=%0d ovf=%0d required=no_output",
                         a_out_sum, a_out_count, a_out_ovf);
            end else begin
                e = qa.pop_front();
                if (longint'(a_out_sum) != e.sum || int'(a_out_count) != e.count || a_out_ovf != e.ovf) begin
                    fails++;
                    $display("FAIL a_result sum=%0d count=%0d ovf=%0d expected sum=%0d count=%0d ovf=%0d",
                             a_out_sum, a_out_count, a_out_ovf, e.sum, e.count, e.ovf);
                end else begin
                    $display("PASS a_result sum=%0d count=%0d ovf=%0d", a_out_sum, a_out_count, a_out_ovf);
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && b_out_valid && b_out_ready) begin
            tests++;
            if (qb.size() == 0) begin
                fails++;
                $display("FAIL b_unexpected sum=%0d count=%0d ovf=%0d required=no_output",
                         b_out_sum, b_out_count, b_out_ovf);
            end else begin
                e = qb.pop_front();
                if (longint'(b_out_sum) != e.sum || int'(b_out_count) != e.count || b_out_ovf != e.ovf) begin
                    fails++;
                    $display("FAIL b_result sum=%0d count=%0d ovf=%0d expected sum=%0d count=%0d ovf=%0d",
                             b_out_sum, b_out_count, b_out_ovf, e.sum, e.count, e.ovf);
                end else begin
                    $display("PASS b_result sum=%0d count=%0d ovf=%0d", b_out_sum, b_out_count, b_out_ovf);
                end
            end
        end
    end

    initial begin
        longint held_sum;
        int     n;
        rst = 1;
        a_in_valid = 0; a_in_prod = 0; a_in_last = 0; a_out_ready = 1;
        b_in_valid = 0; b_in_prod = 0; b_in_last = 0; b_out_ready = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;

        // reset state
        compare("rst_out_valid", a_out_valid, 0);
        compare("rst_in_ready", a_in_ready, 1);
        compare("rst_out_sum", a_out_sum, 0);
        compare("rst_out_count", a_out_count, 0);
        compare("rst_out_ovf", a_out_ovf, 0);
        compare("rst_b_in_ready", b_in_ready, 1);

        // three full-scale products, result held under backpressure
        a_out_ready = 0;
        push(0, 195075, 3, 0);
        send(0, 65025, 0);
        send(0, 65025, 0);
        send(0, 65025, 1);
        compare("latency_out_valid", a_out_valid, 1);
        compare("hold_in_ready", a_in_ready, 0);
        held_sum = a_out_sum;
        compare("hold_sum", held_sum, 195075);
        for (int i = 0; i < 5; i++) begin
            a_in_valid = 1; a_in_prod = 16'd7;
            @(posedge clk); #1;
            compare("hold_stable_sum", a_out_sum, held_sum);
            compare("hold_stable_valid", a_out_valid, 1);
            compare("hold_stable_in_ready", a_in_ready, 0);
        end
        a_in_valid = 0;
        a_out_ready = 1;
        @(posedge clk); #1;
        compare("release_out_valid", a_out_valid, 0);
        compare("release_in_ready", a_in_ready, 1);

        // auto-close at MAX_LEN, 17th beat must stall
        a_out_ready = 0;
        push(0, 1040400, 16, 0);
        for (int i = 0; i < 16; i++) send(0, 65025, 0);
        a_in_valid = 1; a_in_prod = 16'd65025;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            compare("beat17_in_ready", a_in_ready, 0);
        end
        a_in_valid = 0;
        a_out_ready = 1;
        @(posedge clk); #1;
        compare("autoclose_release_valid", a_out_valid, 0);

        // idle bubbles inside a vector
        push(0, 12, 2, 0);
        send(0, 5, 0);
        repeat (3) @(posedge clk);
        #1;
        send(0, 7, 1);

        // overflow on the narrow instance
`ifdef MUL8_DOT_ACC_SAT_EN
        push(1, 65535, 2, 1);
`else
        push(1, 4464, 2, 1);
`endif
        send(1, 40000, 0);
        send(1, 30000, 1);

        // reset mid-vector discards the partial sum
        send(0, 1000, 0);
        send(0, 2000, 0);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        compare("midrst_out_valid", a_out_valid, 0);
        compare("midrst_out_count", a_out_count, 0);
        compare("midrst_in_ready", a_in_ready, 1);
        push(0, 100, 1, 0);
        send(0, 100, 1);

        n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 100) begin
            @(posedge clk); #1; n++;
        end
        compare("scoreboard_drained", qa.size() + qb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
